cfg_bus_arbiter: RTL and testbench
==================================

CFG_BUS_ARBITER -- requirements
Module: cfg_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, WAIT-state cycles before a transaction is aborted (used only with CFG_ARB_TIMEOUT_EN).
REQ-002 i_clk  in  1  sole clock; all logic on rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_m0_request / i_m1_request  in  1  level request, held until the matching ack; m0 = N64 PI side, m1 = MCU side.
REQ-005 i_m0_write / i_m1_write  in  1  1 = write, 0 = read.
REQ-006 i_m0_address / i_m1_address  in  32  target address.
REQ-007 i_m0_wdata / i_m1_wdata  in  32  write data.
REQ-008 o_m0_ack / o_m1_ack  out  1  one-cycle completion pulse.
REQ-009 o_m0_rdata / o_m1_rdata  out  32  read data, valid while the matching ack is high.
REQ-010 o_m0_error / o_m1_error  out  1  timeout flag, high only together with the matching ack.
REQ-011 o_select  out  1  config-slave select, high from ISSUE through WAIT.
REQ-012 o_read_rq / o_write_rq  out  1  one-cycle slave request strobes.
REQ-013 o_address / o_data  out  32  latched address and write data to the slave.
REQ-014 i_ack  in  1  slave acknowledge (registered, one cycle after the strobe).
REQ-015 i_data  in  32  slave read data, sampled when i_ack is high.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: if any request is high, grant the winner, latch its write, address and wdata into o_address/o_data, and go to ISSUE; otherwise stay in IDLE.
REQ-018 Both requesting in IDLE: grant the master not granted last (round-robin); the first arbitration after reset grants m0.
REQ-019 ISSUE: o_select high, exactly one of o_read_rq/o_write_rq high for this one cycle per latched write, then go to WAIT.
REQ-020 WAIT: o_select high and strobes low; on i_ack, capture i_data into the granted master's rdata (writes also capture), update last-grant, and go to DONE.
REQ-021 DONE: granted master's ack high for exactly one cycle, o_select low, then go to IDLE; requests are not sampled in DONE, so no re-grant occurs before the master drops its request.
REQ-022 Latency: request sampled at the end of cycle T in IDLE, strobe in T+1; with a zero-wait slave, ack in T+3.
REQ-023 Changes to a granted master's address, wdata or write after grant are ignored; a non-granted master's request persists until it is served.
REQ-024 i_ack outside WAIT is ignored; o_mX_rdata holds its last captured value between transactions.

Reset
REQ-025 On i_reset: state is IDLE, all acks, errors, strobes and o_select are 0, o_address/o_data/rdata are 0, last-grant = m1.
REQ-026 Reset mid-transaction (ISSUE/WAIT/DONE) abandons it with no ack issued; the master re-requests after reset.

Configuration
REQ-027 Macro CFG_ARB_TIMEOUT_EN defined: a WAIT counter starts at 0 on entry; if it reaches TIMEOUT_CYCLES with no i_ack, go to DONE with ack and error high and rdata = 32'hFFFF_FFFF; i_ack in the same cycle as expiry takes priority (normal completion).
REQ-028 Macro undefined: no counter, WAIT waits indefinitely, o_mX_error tied to 0.

Structure
REQ-029 Shared package cfg_arb_pkg holds: state encoding, master index constants (M0=0, M1=1), default TIMEOUT_CYCLES, and the error read pattern 32'hFFFF_FFFF.
REQ-030 One sub-module, cfg_arb_rr: two-way round-robin picker (requests and last-grant in; grant-valid and grant index out, combinational).

Verification
REQ-031 Single read: m0 reads address 0x0, slave returns 0x0000_0001 one cycle after the strobe -> o_read_rq in T+1, o_m0_ack in T+3, o_m0_rdata = 0x0000_0001, o_m0_error = 0.
REQ-032 Simultaneous: m0 and m1 write 0x1F and 0x03 to address 0x0 from reset -> m0 is served first, then m1; the slave sees two write strobes in order with data 0x1F then 0x03.
REQ-033 Fairness: both requesters held high for 6 transactions -> grants alternate m0, m1, m0, m1, m0, m1; no master is acked twice consecutively.
REQ-034 Timeout (macro on, TIMEOUT_CYCLES=16): slave never acks -> ack and error high exactly 16 cycles after WAIT entry, rdata = 0xFFFF_FFFF; with macro off the arbiter stays in WAIT for 100+ cycles.
REQ-035 Reset in WAIT: assert i_reset one cycle -> no ack, o_select low the next cycle; a later simultaneous request grants m0.

Source files
------------

// File: rtl/cfg_arb_pkg.sv
// cfg_arb_pkg: shared definitions for the configuration-bus arbiter.
//   - FSM state encoding
//   - master index constants (M0 = N64 PI side, M1 = MCU side)
//   - default timeout length and the read pattern returned on a timeout
//   - request payload struct used to mux the winning master onto the slave bus
package cfg_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [DATA_W-1:0] ERR_RDATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
    } cfg_req_t;

endpackage

// File: rtl/cfg_arb_rr.sv
// cfg_arb_rr: two-way round-robin picker, purely combinational.
// Ports:
//   req0, req1     request levels of master 0 / master 1
//   last_grant     index of the master served most recently
//   grant_valid_c  at least one request is pending
//   grant_idx_c    index of the master to serve next
module cfg_arb_rr
    import cfg_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid_c,
    output logic grant_idx_c
);

    // With both requesting, the master not served last wins.
    always_comb begin
        grant_valid_c = req0 | req1;
        grant_idx_c   = M0;
        if (req0 && req1) begin
            grant_idx_c = ~last_grant;
        end else if (req1) begin
            grant_idx_c = M1;
        end
    end

endmodule

// File: rtl/cfg_bus_arbiter.sv
// cfg_bus_arbiter: arbitrates two masters (m0 = N64 PI, m1 = MCU) onto one
// configuration slave. One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Ports:
//   i_clk, i_reset                      clock, synchronous active-high reset
//   i_mX_request/write/address/wdata    master request side (level request)
//   o_mX_ack/rdata/error                master completion side (one-cycle ack)
//   o_select, o_read_rq, o_write_rq     slave select and one-cycle strobes
//   o_address, o_data                   latched address / write data to slave
//   i_ack, i_data                       slave acknowledge and read data
// Optional feature: define CFG_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES cycles in WAIT (ack + error, rdata = all ones). Without it the
// arbiter waits indefinitely and the error outputs stay 0.
module cfg_bus_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
(
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_m0_request,
    input  logic        i_m0_write,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_wdata,
    output logic        o_m0_ack,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_error,

    input  logic        i_m1_request,
    input  logic        i_m1_write,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m1_ack,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_error,

    output logic        o_select,
    output logic        o_read_rq,
    output logic        o_write_rq,
    output logic [31:0] o_address,
    output logic [31:0] o_data,
    input  logic        i_ack,
    input  logic [31:0] i_data
);

    state_t      state_q, state_d;
    logic        gnt_idx_q, gnt_idx_d;
    logic        last_gnt_q, last_gnt_d;

    logic        select_d, read_rq_d, write_rq_d;
    logic [31:0] address_d, data_d;
    logic        m0_ack_d, m1_ack_d, m0_error_d, m1_error_d;
    logic [31:0] m0_rdata_d, m1_rdata_d;

    logic        grant_valid_c, grant_idx_c;
    logic        timeout_c;
    logic [31:0] wait_rdata_c;
    cfg_req_t    m0_req_c, m1_req_c, win_req_c;

    assign m0_req_c     = '{write: i_m0_write, address: i_m0_address, wdata: i_m0_wdata};
    assign m1_req_c     = '{write: i_m1_write, address: i_m1_address, wdata: i_m1_wdata};
    assign win_req_c    = (grant_idx_c == M1) ? m1_req_c : m0_req_c;
    // A slave ack in the expiry cycle wins over the timeout.
    assign wait_rdata_c = i_ack ? i_data : ERR_RDATA;

    cfg_arb_rr u_rr (
        .req0          (i_m0_request),
        .req1          (i_m1_request),
        .last_grant    (last_gnt_q),
        .grant_valid_c (grant_valid_c),
        .grant_idx_c   (grant_idx_c)
    );

`ifdef CFG_ARB_TIMEOUT_EN
    localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

    logic [TO_W-1:0] wait_cnt_q;

    // Cycles spent in the current WAIT; zero on the first WAIT cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset || (state_q != ST_WAIT)) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
        end
    end

    // Leaving WAIT after the last counted cycle puts DONE TIMEOUT_CYCLES after entry.
    assign timeout_c = (state_q == ST_WAIT) && (wait_cnt_q == TO_W'(TO_LIMIT - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_c          = 1'b0;
`endif

    // Next state plus next values of every registered output.
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_gnt_d = last_gnt_q;
        select_d   = 1'b0;
        read_rq_d  = 1'b0;
        write_rq_d = 1'b0;
        address_d  = o_address;
        data_d     = o_data;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_error_d = 1'b0;
        m1_error_d = 1'b0;
        m0_rdata_d = o_m0_rdata;
        m1_rdata_d = o_m1_rdata;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    gnt_idx_d  = grant_idx_c;
                    address_d  = win_req_c.address;
                    data_d     = win_req_c.wdata;
                    select_d   = 1'b1;
                    read_rq_d  = ~win_req_c.write;
                    write_rq_d = win_req_c.write;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                select_d = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_ack || timeout_c) begin
                    last_gnt_d = gnt_idx_q;
                    state_d    = ST_DONE;
                    if (gnt_idx_q == M1) begin
                        m1_ack_d   = 1'b1;
                        m1_error_d = ~i_ack;
                        m1_rdata_d = wait_rdata_c;
                    end else begin
                        m0_ack_d   = 1'b1;
                        m0_error_d = ~i_ack;
                        m0_rdata_d = wait_rdata_c;
                    end
                end else begin
                    select_d = 1'b1;
                end
            end
            ST_DONE: begin
                // Requests are not sampled here so the acked master can drop its request.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            gnt_idx_q  <= M0;
            last_gnt_q <= M1;
            o_select   <= 1'b0;
            o_read_rq  <= 1'b0;
            o_write_rq <= 1'b0;
            o_address  <= '0;
            o_data     <= '0;
            o_m0_ack   <= 1'b0;
            o_m1_ack   <= 1'b0;
            o_m0_error <= 1'b0;
            o_m1_error <= 1'b0;
            o_m0_rdata <= '0;
            o_m1_rdata <= '0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_gnt_q <= last_gnt_d;
            o_select   <= select_d;
            o_read_rq  <= read_rq_d;
            o_write_rq <= write_rq_d;
            o_address  <= address_d;
            o_data     <= data_d;
            o_m0_ack   <= m0_ack_d;
            o_m1_ack   <= m1_ack_d;
            o_m0_error <= m0_error_d;
            o_m1_error <= m1_error_d;
            o_m0_rdata <= m0_rdata_d;
            o_m1_rdata <= m1_rdata_d;
        end
    end

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// tb_cfg_bus_arbiter: self-checking bench for cfg_bus_arbiter.
// A stateless slave model answers every strobe with data = address ^ 1 after a
// programmable number of extra wait cycles and logs each strobe. The grant order
// is predicted from the round-robin rule using per-master transaction queues.
module tb_cfg_bus_arbiter;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_m0_request, i_m0_write, i_m1_request, i_m1_write;
    logic [31:0] i_m0_address, i_m0_wdata, i_m1_address, i_m1_wdata;
    logic        o_m0_ack, o_m0_error, o_m1_ack, o_m1_error;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic        o_select, o_read_rq, o_write_rq;
    logic [31:0] o_address, o_data;
    logic        i_ack;
    logic [31:0] i_data = 32'h0;

    logic        slave_ack = 1'b0;
    logic        spur_ack  = 1'b0;
    assign i_ack = slave_ack | spur_ack;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    bit   slave_en  = 1'b1;
    int   slave_lat = 0;
    int   pend      = 0;
    logic [31:0] pend_data = 32'h0;
    logic        log_w[$];
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];

    txn_t q0[$];
    txn_t q1[$];
    logic model_last = 1'b1;

    cfg_bus_arbiter dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_m0_request (i_m0_request),
        .i_m0_write   (i_m0_write),
        .i_m0_address (i_m0_address),
        .i_m0_wdata   (i_m0_wdata),
        .o_m0_ack     (o_m0_ack),
        .o_m0_rdata   (o_m0_rdata),
        .o_m0_error   (o_m0_error),
        .i_m1_request (i_m1_request),
        .i_m1_write   (i_m1_write),
        .i_m1_address (i_m1_address),
        .i_m1_wdata   (i_m1_wdata),
        .o_m1_ack     (o_m1_ack),
        .o_m1_rdata   (o_m1_rdata),
        .o_m1_error   (o_m1_error),
        .o_select     (o_select),
        .o_read_rq    (o_read_rq),
        .o_write_rq   (o_write_rq),
        .o_address    (o_address),
        .o_data       (o_data),
        .i_ack        (i_ack),
        .i_data       (i_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slave_value(input logic [31:0] a);
        return a ^ 32'h0000_0001;
    endfunction

    // Slave: registered ack one cycle after the strobe plus slave_lat extra cycles.
    always @(posedge clk) begin
        slave_ack <= 1'b0;
        if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                slave_ack <= 1'b1;
                i_data    <= pend_data;
            end
        end
        if (o_read_rq || o_write_rq) begin
            log_w.push_back(o_write_rq);
            log_a.push_back(o_address);
            log_d.push_back(o_data);
            if (slave_en) begin
                if (slave_lat == 0) begin
                    slave_ack <= 1'b1;
                    i_data    <= slave_value(o_address);
                end else begin
                    pend      <= slave_lat;
                    pend_data <= slave_value(o_address);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            tick();
            cycles++;
            if (o_m0_ack || o_m1_ack) seen = 1'b1;
        end
    endtask

    task automatic present(input logic idx);
        if (idx == 1'b0) begin
            if (q0.size() > 0) begin
                i_m0_request = 1'b1; i_m0_write = q0[0].w;
                i_m0_address = q0[0].a; i_m0_wdata = q0[0].d;
            end else begin
                i_m0_request = 1'b0; i_m0_address = $urandom; i_m0_wdata = $urandom;
            end
        end else begin
            if (q1.size() > 0) begin
                i_m1_request = 1'b1; i_m1_write = q1[0].w;
                i_m1_address = q1[0].a; i_m1_wdata = q1[0].d;
            end else begin
                i_m1_request = 1'b0; i_m1_address = $urandom; i_m1_wdata = $urandom;
            end
        end
    endtask

    // Serve everything queued on both masters; requests stay up until served.
    task automatic serve_round(input string tag);
        logic order[$];
        int   n0;
        int   n1;
        logic last;
        logic pick;
        bit   seen;
        int   cyc;
        txn_t t;
        logic [31:0] rd;
        logic        er;
        n0   = q0.size();
        n1   = q1.size();
        last = model_last;
        while (n0 > 0 || n1 > 0) begin
            if (n0 > 0 && n1 > 0) pick = ~last;
            else                  pick = (n0 > 0) ? 1'b0 : 1'b1;
            order.push_back(pick);
            if (pick) n1--; else n0--;
            last = pick;
        end
        model_last = last;
        log_w.delete(); log_a.delete(); log_d.delete();
        present(1'b0);
        present(1'b1);
        foreach (order[k]) begin
            wait_ack(60, seen, cyc);
            check($sformatf("%s_ack_seen%0d", tag, k), 32'(seen), 32'd1);
            if (!seen) return;
            check($sformatf("%s_grant%0d", tag, k), 32'(o_m1_ack), 32'(order[k]));
            check($sformatf("%s_dual_ack%0d", tag, k), 32'(o_m0_ack & o_m1_ack), 32'd0);
            t  = order[k] ? q1[0] : q0[0];
            rd = order[k] ? o_m1_rdata : o_m0_rdata;
            er = order[k] ? o_m1_error : o_m0_error;
            check($sformatf("%s_rdata%0d", tag, k), rd, slave_value(t.a));
            check($sformatf("%s_error%0d", tag, k), 32'(er), 32'd0);
            check($sformatf("%s_strobes%0d", tag, k), 32'(log_a.size()), 32'd1);
            if (log_a.size() > 0) begin
                check($sformatf("%s_st_write%0d", tag, k), 32'(log_w.pop_front()), 32'(t.w));
                check($sformatf("%s_st_addr%0d", tag, k), log_a.pop_front(), t.a);
                check($sformatf("%s_st_data%0d", tag, k), log_d.pop_front(), t.d);
            end
            if (order[k]) void'(q1.pop_front()); else void'(q0.pop_front());
            present(order[k]);
            slave_lat = $urandom_range(0, 3);
        end
        tick();
    endtask

    initial begin
        bit   seen;
        bit   hang_ok;
        int   cyc;
        txn_t t;

        i_reset = 1'b1;
        i_m0_request = 1'b0; i_m0_write = 1'b0; i_m0_address = 32'h0; i_m0_wdata = 32'h0;
        i_m1_request = 1'b0; i_m1_write = 1'b0; i_m1_address = 32'h0; i_m1_wdata = 32'h0;
        repeat (3) tick();

        // Reset values
        check("rst_ctrl", 32'({o_select, o_read_rq, o_write_rq, o_m0_ack, o_m1_ack,
                               o_m0_error, o_m1_error}), 32'd0);
        check("rst_address", o_address, 32'h0);
        check("rst_data", o_data, 32'h0);
        check("rst_m0_rdata", o_m0_rdata, 32'h0);
        check("rst_m1_rdata", o_m1_rdata, 32'h0);
        i_reset = 1'b0;
        tick();

        // Single read from m0, zero-wait slave: strobe T+1, ack T+3
        i_m0_request = 1'b1; i_m0_write = 1'b0; i_m0_address = 32'h0;
        tick();
        check("rd_t1_read_rq", 32'(o_read_rq), 32'd1);
        check("rd_t1_write_rq", 32'(o_write_rq), 32'd0);
        check("rd_t1_select", 32'(o_select), 32'd1);
        check("rd_t1_address", o_address, 32'h0);
        tick();
        check("rd_t2_read_rq", 32'(o_read_rq), 32'd0);
        check("rd_t2_select", 32'(o_select), 32'd1);
        check("rd_t2_ack", 32'(o_m0_ack), 32'd0);
        tick();
        check("rd_t3_ack", 32'(o_m0_ack), 32'd1);
        check("rd_t3_m1_ack", 32'(o_m1_ack), 32'd0);
        check("rd_t3_rdata", o_m0_rdata, 32'h0000_0001);
        check("rd_t3_error", 32'(o_m0_error), 32'd0);
        check("rd_t3_select", 32'(o_select), 32'd0);
        i_m0_request = 1'b0;
        tick();
        check("rd_t4_ack_pulse", 32'(o_m0_ack), 32'd0);
        check("rd_t4_rdata_hold", o_m0_rdata, 32'h0000_0001);
        model_last = 1'b0;

        // Stray slave ack while idle must be ignored
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        tick();
        check("spur_ack", 32'({o_m0_ack, o_m1_ack, o_select}), 32'd0);
        check("spur_rdata", o_m0_rdata, 32'h0000_0001);

        // Granted master's fields change after grant: latched copy is used
        i_m0_request = 1'b1; i_m0_write = 1'b1;
        i_m0_address = 32'h0000_0100; i_m0_wdata = 32'hCAFE_0001;
        tick();
        check("lat_write_rq", 32'(o_write_rq), 32'd1);
        check("lat_address", o_address, 32'h0000_0100);
        check("lat_data", o_data, 32'hCAFE_0001);
        i_m0_write = 1'b0; i_m0_address = 32'h0000_0200; i_m0_wdata = 32'h0000_DEAD;
        wait_ack(10, seen, cyc);
        check("lat_ack_seen", 32'(seen), 32'd1);
        check("lat_rdata", o_m0_rdata, 32'h0000_0101);
        check("lat_address_hold", o_address, 32'h0000_0100);
        i_m0_request = 1'b0;
        tick();
        model_last = 1'b0;

        // Simultaneous writes from reset: m0 first, then m1
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        model_last = 1'b1;
        t = '{w: 1'b1, a: 32'h0, d: 32'h0000_001F}; q0.push_back(t);
        t = '{w: 1'b1, a: 32'h0, d: 32'h0000_0003}; q1.push_back(t);
        serve_round("simul");

        // Fairness: both held high for six transactions
        for (int i = 0; i < 3; i++) begin
            t = '{w: 1'b0, a: 32'h10 + 32'(i), d: 32'h0}; q0.push_back(t);
            t = '{w: 1'b1, a: 32'h20 + 32'(i), d: 32'hA0 + 32'(i)}; q1.push_back(t);
        end
        serve_round("fair");

        // Randomised rounds with random slave latency
        for (int r = 0; r < 8; r++) begin
            int n0;
            int n1;
            n0 = $urandom_range(0, 4);
            n1 = $urandom_range(0, 4);
            for (int i = 0; i < n0; i++) begin
                t.w = 1'($urandom_range(0, 1)); t.a = $urandom; t.d = $urandom;
                q0.push_back(t);
            end
            for (int i = 0; i < n1; i++) begin
                t.w = 1'($urandom_range(0, 1)); t.a = $urandom; t.d = $urandom;
                q1.push_back(t);
            end
            serve_round($sformatf("rnd%0d", r));
            repeat ($urandom_range(0, 3)) tick();
        end

        // Slave never answers
        slave_en  = 1'b0;
        slave_lat = 0;
        i_m0_request = 1'b1; i_m0_write = 1'b0; i_m0_address = 32'h44;
`ifdef CFG_ARB_TIMEOUT_EN
        wait_ack(40, seen, cyc);
        check("to_ack_seen", 32'(seen), 32'd1);
        check("to_latency", 32'(cyc), 32'd18);
        check("to_error", 32'(o_m0_error), 32'd1);
        check("to_rdata", o_m0_rdata, 32'hFFFF_FFFF);
        i_m0_request = 1'b0;
        tick();
        i_m0_request = 1'b1;
        repeat (4) tick();
        check("to_in_wait", 32'(o_select), 32'd1);
`else
        tick();
        hang_ok = 1'b1;
        repeat (110) begin
            tick();
            if (!o_select || o_m0_ack || o_m1_ack) hang_ok = 1'b0;
        end
        check("hang_110", 32'(hang_ok), 32'd1);
        check("hang_error", 32'({o_m0_error, o_m1_error}), 32'd0);
`endif

        // One-cycle reset while in WAIT abandons the transaction
        i_reset = 1'b1;
        i_m0_request = 1'b0;
        tick();
        i_reset = 1'b0;
        check("rstw_select", 32'(o_select), 32'd0);
        check("rstw_ack", 32'({o_m0_ack, o_m1_ack}), 32'd0);
        hang_ok = 1'b1;
        repeat (3) begin
            tick();
            if (o_m0_ack || o_m1_ack || o_select) hang_ok = 1'b0;
        end
        check("rstw_quiet", 32'(hang_ok), 32'd1);
        slave_en   = 1'b1;
        model_last = 1'b1;
        t = '{w: 1'b0, a: 32'h80, d: 32'h0}; q0.push_back(t);
        t = '{w: 1'b1, a: 32'h84, d: 32'h5A5A_0001}; q1.push_back(t);
        serve_round("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
